// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670-style DVP source.
package cam_pkg;

    typedef enum logic [1:0] {PAT_HGRAD, PAT_VGRAD, PAT_CHECK, PAT_EXT} pattern_t;
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

endpackage

// File: rtl/dvp_timing_gen.sv
// PCLK phase generator plus byte/line raster counters for the DVP source.
module dvp_timing_gen
    import cam_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int BLANK_WIDTH  = 144,
    parameter int BLANK_HEIGHT = 30,
    parameter int VSYNC_LINES  = 3,
    parameter int V_OFFSET     = 20
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       run,
    output logic       pclk,
    output logic       byte_load,
    output logic       vsync,
    output logic       href,
    output logic       odd,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       frame_last
);

    localparam int FRAME_WIDTH  = IMAGE_WIDTH + BLANK_WIDTH;
    localparam int FRAME_HEIGHT = IMAGE_HEIGHT + BLANK_HEIGHT;
    localparam int LINE_BYTES   = 2 * FRAME_WIDTH;
    localparam int BYTE_W       = $clog2(LINE_BYTES);
    localparam int LINE_W       = $clog2(FRAME_HEIGHT);

    logic              pclk_q, pclk_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [31:0]       byte_ext, line_ext;
    logic              line_end;

    always_comb begin
        byte_ext   = 32'(byte_cnt_q);
        line_ext   = 32'(line_cnt_q);
        line_end   = (byte_ext == LINE_BYTES - 1);
        pclk_d     = run ? ~pclk_q : 1'b0;
        // Counters step on the PCLK falling edge, i.e. the clk edge where pclk_q is high.
        byte_load  = run & pclk_q;
        frame_last = line_end && (line_ext == FRAME_HEIGHT - 1);
        vsync      = (line_ext < VSYNC_LINES);
        href       = (line_ext >= V_OFFSET) && (line_ext < V_OFFSET + IMAGE_HEIGHT)
                     && (byte_ext < 2 * IMAGE_WIDTH);
        odd        = byte_cnt_q[0];
        x          = 8'(byte_cnt_q >> 1);
        y          = 8'(line_ext - V_OFFSET);
        byte_cnt_d = byte_cnt_q;
        line_cnt_d = line_cnt_q;
        if (byte_load) begin
            if (line_end) begin
                byte_cnt_d = '0;
                line_cnt_d = (line_ext == FRAME_HEIGHT - 1) ? '0 : line_cnt_q + LINE_W'(1);
            end else begin
                byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pclk_q     <= 1'b0;
            byte_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            pclk_q     <= pclk_d;
            byte_cnt_q <= byte_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign pclk = pclk_q;

endmodule

// File: rtl/ov7670_dvp_tx.sv
// OV7670-style DVP camera source: frame FSM and YUV422 (U,Y,V,Y) pattern mux.
module ov7670_dvp_tx
    import cam_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int BLANK_WIDTH  = 144,
    parameter int BLANK_HEIGHT = 30,
    parameter int VSYNC_LINES  = 3,
    parameter int V_OFFSET     = 20
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    input  logic [7:0] px_y,
    output logic       px_req,
    output logic       cam_PCLK,
    output logic       cam_VSYNC,
    output logic       cam_HREF,
    output logic [7:0] cam_D,
    output logic       busy,
    output logic       frame_done
);

    if (VSYNC_LINES < 1 || VSYNC_LINES > V_OFFSET || V_OFFSET > BLANK_HEIGHT) begin : g_bad_geometry
        $error("ov7670_dvp_tx: need 1 <= VSYNC_LINES <= V_OFFSET <= BLANK_HEIGHT");
    end

    state_t     state_q, state_d;
    pattern_t   pat_q, pat_d;
    logic       busy_q, busy_d;
    logic       last_q, last_d;
    logic       done_q, done_d;
    logic       vsync_q, vsync_d;
    logic       href_q, href_d;
    logic [7:0] data_q, data_d;
    logic       run, stop;

    logic       tg_pclk, tg_load, tg_vsync, tg_href, tg_odd, tg_last;
    logic [7:0] tg_x, tg_y;

    dvp_timing_gen #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .BLANK_WIDTH (BLANK_WIDTH),
        .BLANK_HEIGHT(BLANK_HEIGHT),
        .VSYNC_LINES (VSYNC_LINES),
        .V_OFFSET    (V_OFFSET)
    ) u_timing (
        .clk       (clk),
        .n_rst     (n_rst),
        .run       (run),
        .pclk      (tg_pclk),
        .byte_load (tg_load),
        .vsync     (tg_vsync),
        .href      (tg_href),
        .odd       (tg_odd),
        .x         (tg_x),
        .y         (tg_y),
        .frame_last(tg_last)
    );

    function automatic logic [7:0] luma(input pattern_t pat, input logic [7:0] x,
                                        input logic [7:0] y, input logic [7:0] ext);
        case (pat)
            PAT_HGRAD: luma = x;
            PAT_VGRAD: luma = y;
            PAT_CHECK: luma = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            default:   luma = ext;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        busy_d  = busy_q;
        vsync_d = vsync_q;
        href_d  = href_q;
        data_d  = data_q;
        // frame_done_q marks the clk edge where the next frame would start; that is the only exit point.
        stop    = (state_q == S_RUN) && done_q && !enable;
        run     = (state_q == S_RUN) && !stop;
        last_d  = tg_load && tg_last;
        done_d  = last_q;
        px_req  = tg_load && tg_href && tg_odd && (pat_q == PAT_EXT);
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    pat_d   = pattern_t'(pattern_sel);
                end
            end
            default: begin
                if (done_q) begin
                    if (enable) begin
                        pat_d = pattern_t'(pattern_sel);
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        vsync_d = 1'b0;
                        href_d  = 1'b0;
                        data_d  = 8'h00;
                    end
                end
            end
        endcase
        if (tg_load) begin
            vsync_d = tg_vsync;
            href_d  = tg_href;
            if (!tg_href)
                data_d = 8'h00;
            else if (tg_odd)
                data_d = luma(pat_q, tg_x, tg_y, px_y);
            else
                data_d = CHROMA_NEUTRAL;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            pat_q   <= PAT_HGRAD;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            done_q  <= done_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
        end
    end

    assign cam_PCLK   = tg_pclk;
    assign cam_VSYNC  = vsync_q;
    assign cam_HREF   = href_q;
    assign cam_D      = data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ov7670_dvp_tx.sv
// Directed bench for ov7670_dvp_tx on a small 8x4 geometry (blank 4x6, one VSYNC line, V_OFFSET 2).
module tb_ov7670_dvp_tx;

    localparam int IW = 8;
    localparam int IH = 4;
    localparam int BW = 4;
    localparam int BH = 6;
    localparam int VS = 1;
    localparam int VO = 2;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       enable;
    logic [1:0] pattern_sel;
    logic [7:0] px_y = 8'h00;
    logic       px_req, cam_PCLK, cam_VSYNC, cam_HREF, busy, frame_done;
    logic [7:0] cam_D;

    int checks = 0;
    int errors = 0;

    // Receiver-side monitor state
    logic [7:0] cap[$];
    int   rise_cnt, href_bytes, href_pulses, vs_samples, fd_cnt, px_cnt, pclk_bad = 0;
    logic vs_r1, vs_r2, pclk_prev = 1'b0, href_prev_s;
    logic [9:0] prev_out = '0;
    int   n;

    ov7670_dvp_tx #(
        .IMAGE_WIDTH (IW),
        .IMAGE_HEIGHT(IH),
        .BLANK_WIDTH (BW),
        .BLANK_HEIGHT(BH),
        .VSYNC_LINES (VS),
        .V_OFFSET    (VO)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .px_y       (px_y),
        .px_req     (px_req),
        .cam_PCLK   (cam_PCLK),
        .cam_VSYNC  (cam_VSYNC),
        .cam_HREF   (cam_HREF),
        .cam_D      (cam_D),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Samples 1 time unit after each clk edge; a PCLK rise is where a receiver would capture.
    always @(posedge clk) begin
        #1;
        px_y = 8'(px_cnt);
        if (px_req) px_cnt++;
        if (frame_done) fd_cnt++;
        if (cam_PCLK && !pclk_prev) begin
            rise_cnt++;
            if (rise_cnt == 1) vs_r1 = cam_VSYNC;
            if (rise_cnt == 2) vs_r2 = cam_VSYNC;
            if ({cam_VSYNC, cam_HREF, cam_D} != prev_out) pclk_bad++;
            if (cam_HREF) begin
                cap.push_back(cam_D);
                href_bytes++;
                if (!href_prev_s) href_pulses++;
            end
            if (cam_VSYNC) vs_samples++;
            href_prev_s = cam_HREF;
        end
        if (cam_PCLK && !busy) pclk_bad++;
        pclk_prev = cam_PCLK;
        prev_out  = {cam_VSYNC, cam_HREF, cam_D};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic clr();
        cap.delete();
        rise_cnt = 0; href_bytes = 0; href_pulses = 0; vs_samples = 0;
        fd_cnt = 0; px_cnt = 0; vs_r1 = 1'bx; vs_r2 = 1'bx; href_prev_s = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (frame_done !== 1'b1 && cnt < budget);
        chk("frame_done_reached", 32'(frame_done), 32'd1);
    endtask

    function automatic logic [7:0] exp_byte(input int mode, input int i);
        logic [7:0] xv;
        logic [7:0] yv;
        xv = 8'((i % 16) / 2);
        yv = 8'(i / 16);
        if ((i % 2) == 0) return 8'h80;
        case (mode)
            0:       return xv;
            1:       return yv;
            2:       return (xv[3] ^ yv[3]) ? 8'hFF : 8'h00;
            default: return 8'(i / 2);
        endcase
    endfunction

    task automatic check_cap(input int mode, input string tag);
        chk({tag, "_len"}, 32'(cap.size()), 32'd64);
        for (int i = 0; i < cap.size() && i < 64; i++)
            chk(tag, {24'h0, cap[i]}, {24'h0, exp_byte(mode, i)});
    endtask

    initial begin
        n_rst = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
        clr();
        step(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pclk", 32'(cam_PCLK), 0);
        chk("rst_vsync", 32'(cam_VSYNC), 0);
        chk("rst_href", 32'(cam_HREF), 0);
        chk("rst_d", 32'(cam_D), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_pxreq", 32'(px_req), 0);
        n_rst = 1'b1;
        step(3);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_pclk", 32'(cam_PCLK), 0);

        // Mode 0 streaming, enable held
        clr(); pattern_sel = 2'd0; enable = 1'b1;
        step(1);
        chk("start_busy", 32'(busy), 1);
        chk("start_pclk_low", 32'(cam_PCLK), 0);
        step(1);
        chk("start_pclk_rise", 32'(cam_PCLK), 1);
        wait_done(600, n);
        chk("f1_rises", 32'(rise_cnt), 241);
        chk("f1_vs_lead", 32'(vs_r1), 0);
        chk("f1_vs_line0", 32'(vs_r2), 1);
        chk("f1_href_bytes", 32'(href_bytes), 64);
        chk("f1_href_pulses", 32'(href_pulses), 4);
        chk("f1_vsync_bytes", 32'(vs_samples), 24);
        chk("f1_done_pulses", 32'(fd_cnt), 1);
        chk("f1_no_pxreq", 32'(px_cnt), 0);
        check_cap(0, "hgrad");
        clr();
        wait_done(600, n);
        chk("frame_period", 32'(n), 480);
        chk("f2_rises", 32'(rise_cnt), 240);
        chk("f2_href_bytes", 32'(href_bytes), 64);
        chk("f2_href_pulses", 32'(href_pulses), 4);
        chk("f2_vsync_bytes", 32'(vs_samples), 24);
        chk("f2_done_pulses", 32'(fd_cnt), 1);

        // Drop enable mid-frame: frame must complete
        clr();
        step(100);
        enable = 1'b0;
        wait_done(600, n);
        chk("drop_remaining", 32'(n), 380);
        chk("drop_busy_at_done", 32'(busy), 1);
        chk("drop_rises", 32'(rise_cnt), 240);
        chk("drop_href_bytes", 32'(href_bytes), 64);
        step(1);
        chk("drop_busy_low", 32'(busy), 0);
        chk("drop_pclk_low", 32'(cam_PCLK), 0);
        step(20);
        chk("drop_pclk_held", 32'(cam_PCLK), 0);
        chk("drop_done_once", 32'(fd_cnt), 1);
        chk("drop_idle_busy", 32'(busy), 0);

        // External Y source, single frame; pattern_sel changed after latching
        clr(); pattern_sel = 2'd3; enable = 1'b1;
        step(1);
        pattern_sel = 2'd0; enable = 1'b0;
        wait_done(600, n);
        chk("ext_pxreq_cnt", 32'(px_cnt), 32);
        chk("ext_rises", 32'(rise_cnt), 241);
        check_cap(3, "ext");
        step(2);
        chk("ext_idle", 32'(busy), 0);

        // Vertical gradient and checker
        for (int m = 1; m <= 2; m++) begin
            clr(); pattern_sel = 2'(m); enable = 1'b1;
            step(1);
            pattern_sel = 2'd0; enable = 1'b0;
            wait_done(600, n);
            chk("pat_no_pxreq", 32'(px_cnt), 0);
            check_cap(m, (m == 1) ? "vgrad" : "check");
            step(2);
        end

        // Asynchronous reset in the middle of an active line
        clr(); pattern_sel = 2'd0; enable = 1'b1;
        step(200);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_href", 32'(cam_HREF), 1);
        chk("mid_d", 32'(cam_D), 32'h80);
        n_rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pclk", 32'(cam_PCLK), 0);
        chk("arst_vsync", 32'(cam_VSYNC), 0);
        chk("arst_href", 32'(cam_HREF), 0);
        chk("arst_d", 32'(cam_D), 0);
        chk("arst_done", 32'(frame_done), 0);
        step(2);
        n_rst = 1'b1;
        clr();
        step(1);
        chk("rearm_busy", 32'(busy), 1);
        enable = 1'b0;
        wait_done(600, n);
        chk("rearm_rises", 32'(rise_cnt), 241);
        chk("rearm_vs_lead", 32'(vs_r1), 0);
        chk("rearm_vs_line0", 32'(vs_r2), 1);
        chk("rearm_href_bytes", 32'(href_bytes), 64);
        check_cap(0, "rearm");
        step(2);

        chk("pclk_phase_violations", 32'(pclk_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
